alu_deserializer: RTL and testbench

ALU_DESERIALIZER -- requirements
Module: alu_deserializer

---
 rtl/alu_deserializer.sv | 193 +++++++++++++++++++
 tb/tb_alu_deserializer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_deserializer.sv
// alu_deserializer
// Receives a serial ALU request and presents it as a parallel frame.
// A request is 8 data packets (B MSB byte first, then A) followed by one
// command packet carrying {1'b0, op, crc4}. Every packet is 11 bits:
// start (0), type (0 data / 1 cmd), 8-bit payload MSB first, stop (1).
//
// Optional feature: define ALU_DESER_CRC_CHECK_EN to build the CRC4 checker
// (x^4+x+1, init 0, over {B, A, 1'b1, op}). When it is not defined, no CRC
// logic exists and error_flags[1] is always 0.
//
// Ports
//   clk         : single rising-edge clock
//   rst         : synchronous active-high reset
//   sin         : serial input, one bit per clk, idles high
//   out_valid   : a decoded frame is held on A/B/op/error_flags
//   out_ready   : downstream accepts the held frame this cycle
//   A, B        : operands as received (missing bytes read 0)
//   op          : operation code from the command packet
//   error_flags : {data count, crc, op} error, one-hot by priority
//   frame_err   : one-cycle pulse on a bad stop bit
//   overrun     : one-cycle pulse when a completed frame is dropped
//   dbg_state   : packet FSM state (IDLE=0, TYPE=1, PAYLOAD=2, STOP=3)
//
// Handshake: the output frame transfers on a cycle where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the frame fields
// are frozen; a frame completing then is dropped and flagged by overrun.
module alu_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic [2:0]  error_flags,
  output logic        frame_err,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TYPE    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  bit_cnt;
  logic        pkt_type;
  logic [7:0]  payload;
  logic [3:0]  data_cnt;   // saturates at 9 so "too many" stays visible
  logic [63:0] data_q;     // {B, A}, filled byte by byte from the top
  logic        pkt_done;
  logic        pkt_bad;
  logic        data_done;
  logic        cmd_done;
  logic        hold_busy;
  logic        crc_ok;
  logic [2:0]  err_next;

  assign dbg_state = state;

  // ---------------- packet FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!sin) state_next = S_TYPE;
      S_TYPE:    state_next = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == 3'd7) state_next = S_STOP;
      S_STOP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign pkt_done  = (state == S_STOP) && sin;
  assign pkt_bad   = (state == S_STOP) && !sin;
  assign data_done = pkt_done && !pkt_type;
  assign cmd_done  = pkt_done && pkt_type;
  assign hold_busy = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      pkt_type <= 1'b0;
      payload  <= 8'd0;
    end else begin
      case (state)
        S_TYPE: begin
          pkt_type <= sin;
          bit_cnt  <= 3'd0;
        end
        S_PAYLOAD: begin
          payload <= {payload[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- frame assembly ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt <= 4'd0;
      data_q   <= 64'd0;
    end else if (pkt_bad || cmd_done) begin
      // A bad stop bit abandons the frame; a command closes it.
      data_cnt <= 4'd0;
      data_q   <= 64'd0;
    end else if (data_done) begin
      for (int i = 0; i < 8; i++) begin
        if (data_cnt == 4'(i)) data_q[(7 - i) * 8 +: 8] <= payload;
      end
      if (data_cnt != 4'd9) data_cnt <= data_cnt + 4'd1;
    end
  end

`ifdef ALU_DESER_CRC_CHECK_EN
  logic [3:0] crc;
  logic [3:0] crc_data_next;
  logic [3:0] crc_final;

  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = d ^ c[3];
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // The data bytes arrive in the same order the CRC consumes them, so the
  // running CRC is advanced one byte per data packet; the {1'b1, op} tail
  // is folded in when the command packet completes.
  always_comb begin
    crc_data_next = crc;
    for (int i = 7; i >= 0; i--) crc_data_next = crc4_step(crc_data_next, payload[i]);
    crc_final = crc4_step(crc, 1'b1);
    for (int i = 6; i >= 4; i--) crc_final = crc4_step(crc_final, payload[i]);
  end

  assign crc_ok = (crc_final == payload[3:0]);

  always_ff @(posedge clk) begin
    if (rst || pkt_bad || cmd_done) crc <= 4'd0;
    else if (data_done && (data_cnt < 4'd8)) crc <= crc_data_next;
  end
`else
  assign crc_ok = 1'b1;
`endif

  // Valid ops are 000, 001, 100, 101: exactly those with op[1] = 0.
  always_comb begin
    err_next = 3'b000;
    if (data_cnt != 4'd8) err_next = 3'b100;
    else if (!crc_ok)     err_next = 3'b010;
    else if (payload[5])  err_next = 3'b001;
  end

  // ---------------- output frame ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      A           <= 32'd0;
      B           <= 32'd0;
      op          <= 3'd0;
      error_flags <= 3'd0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= pkt_bad;
      overrun   <= 1'b0;
      if (cmd_done && !hold_busy) begin
        // Also covers accept-and-reload in the same cycle.
        out_valid   <= 1'b1;
        B           <= data_q[63:32];
        A           <= data_q[31:0];
        op          <= payload[6:4];
        error_flags <= err_next;
      end else if (cmd_done) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_deserializer.sv
// Testbench for alu_deserializer: directed request frames with hand-computed
// responses, one task per scenario, and a single summary line at the end.
module tb_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic [2:0]  error_flags;
  logic        frame_err;
  logic        overrun;
  logic [1:0]  dbg_state;

  int tests  = 0;
  int failed = 0;

  logic [70:0] got_v;
  logic [70:0] exp_v;

`ifdef ALU_DESER_CRC_CHECK_EN
  localparam logic [2:0] CRC_ERR_EXP = 3'b010;
`else
  localparam logic [2:0] CRC_ERR_EXP = 3'b000;
`endif

  alu_deserializer dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .A           (A),
    .B           (B),
    .op          (op),
    .error_flags (error_flags),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference CRC (from the polynomial definition) ----------------
  function automatic logic [3:0] crc_model(input logic [63:0] ba, input logic [2:0] o);
    logic [67:0] bits;
    logic [3:0]  c;
    logic        fb;
    bits = {ba, 1'b1, o};
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = bits[i] ^ c[3];
      c = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // ---------------- drivers ----------------
  // Drives one 11-bit packet, one bit per negedge; returns right after the
  // stop bit has been driven (the DUT samples it on the next posedge).
  task automatic send_packet(input logic typ, input logic [7:0] b, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, b, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = bits[i];
    end
  endtask

  // Sends n data packets taken from d, most significant byte first.
  task automatic send_data(input int n, input logic [63:0] d);
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      t = (i < 8) ? (d << (8 * i)) : 64'd0;
      send_packet(1'b0, t[63:56], 1'b1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    sin = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, frame_err, overrun} !== 3'b000) begin
      failed++; $display("FAIL reset_flags: got %b want 000", {out_valid, frame_err, overrun});
    end
    got_v = {out_valid, B, A, op, error_flags};
    tests++;
    if (got_v !== 71'd0) begin
      failed++; $display("FAIL reset_data: got %h want 0", got_v);
    end
    tests++;
    if (dbg_state !== 2'd0) begin
      failed++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_and;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL good_early: out_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL good_frame: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL good_accept: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_order;
    logic [63:0] d;
    logic [3:0]  c;
    d = 64'h0102030405060708;
    c = crc_model(d, 3'b101);
    send_data(8, d);
    send_packet(1'b1, {1'b0, 3'b101, c}, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h01020304, 32'h05060708, 3'b101, 3'b000};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL order_frame: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_crc_err;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0A, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, CRC_ERR_EXP};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL crc_err: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short;
    send_data(7, 64'h1122334455667788);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h11223344, 32'h55667700, 3'b000, 3'b100};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL short_frame: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_long;
    send_data(9, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b100};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL long_frame: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_op;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h2D, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b010, 3'b001};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL bad_op: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_err;
    send_data(2, 64'd0);
    send_packet(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    sin = 1'b1;
    tests++;
    if ({frame_err, out_valid} !== 2'b10) begin
      failed++; $display("FAIL frame_err_pulse: {frame_err,out_valid} got %b want 10", {frame_err, out_valid});
    end
    @(posedge clk); #1;
    tests++;
    if ({frame_err, out_valid} !== 2'b00) begin
      failed++; $display("FAIL frame_err_len: {frame_err,out_valid} got %b want 00", {frame_err, out_valid});
    end
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL frame_err_recover: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000};
    send_data(8, 64'hFFFFFFFFFFFFFFFF);
    got_v = {out_valid, B, A, op, error_flags};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL bp_hold: got %h want %h", got_v, exp_v);
    end
    send_packet(1'b1, 8'h2D, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    tests++;
    if (overrun !== 1'b1) begin
      failed++; $display("FAIL bp_overrun: got %b want 1", overrun);
    end
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL bp_kept: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
    tests++;
    if (overrun !== 1'b0) begin
      failed++; $display("FAIL bp_overrun_len: got %b want 0", overrun);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL bp_release: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d;
    logic [3:0]  c;
    out_ready = 1'b0;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    d = 64'h0102030405060708;
    c = crc_model(d, 3'b101);
    send_data(8, d);
    send_packet(1'b1, {1'b0, 3'b101, c}, 1'b1);
    out_ready = 1'b1;   // accept the held frame on the edge the new one completes
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h01020304, 32'h05060708, 3'b101, 3'b000};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL b2b_reload: got %h want %h", got_v, exp_v);
    end
    tests++;
    if (overrun !== 1'b0) begin
      failed++; $display("FAIL b2b_no_overrun: got %b want 0", overrun);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_drop: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    send_data(3, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk); sin = 1'b0;   // start
    @(negedge clk); sin = 1'b0;   // type = data
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    tests++;
    if ({got_v, frame_err, overrun, dbg_state} !== 75'd0) begin
      failed++; $display("FAIL rst_mid_outputs: got %h/%b%b st %0d want all 0", got_v, frame_err, overrun, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    sin = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, frame_err, overrun} !== 3'b000) begin
        failed++; $display("FAIL rst_mid_quiet: got %b want 000", {out_valid, frame_err, overrun});
      end
    end
    send_data(8, 64'd0);
    send_packet(1'b1, 8'h0B, 1'b1);
    @(posedge clk); #1;
    got_v = {out_valid, B, A, op, error_flags};
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000};
    tests++;
    if (got_v !== exp_v) begin
      failed++; $display("FAIL rst_mid_next: got %h want %h", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_and();
    test_order();
    test_crc_err();
    test_short();
    test_long();
    test_bad_op();
    test_frame_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
